decode_stage: RTL

- Registered, handshaked instruction-decode stage for the 16-bit Thumb-subset core; sits between fetch and register-file/ALU issue.
- Generalises the combinational decoder with configurable register-address and data widths and a fully defined decode table.
- Adds an illegal-instruction flag, a valid/ready pipeline register, flush, and a two-halfword BL sequencer FSM.

---
 rtl/decode_pkg.sv | 90 +++++++++
 rtl/decode_comb.sv | 112 +++++++++++
 rtl/decode_stage.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - shared types and constants for the Thumb-subset decode stage
//
// Holds the ALU/shifter operation encodings, condition codes, special
// register indices, the BL sequencer state enum and the decoded bundle.
// The bundle carries 4-bit register fields and a 32-bit sign-correct
// immediate; decode_stage resizes them to REG_AW / DATA_W on output.
package decode_pkg;

  localparam logic [3:0] SP_IDX = 4'd13;
  localparam logic [3:0] LR_IDX = 4'd14;
  localparam logic [3:0] PC_IDX = 4'd15;

  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam logic [4:0] BL_HI_PFX = 5'b11110;
  localparam logic [4:0] BL_LO_PFX = 5'b11111;

  typedef enum logic [2:0] {
    ALU_NONE = 3'b000,
    ALU_ADD  = 3'b001,
    ALU_SUB  = 3'b010,
    ALU_AND  = 3'b011,
    ALU_EOR  = 3'b100,
    ALU_ORR  = 3'b101,
    ALU_MVN  = 3'b110,
    ALU_CMP  = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_op_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_BL_WAIT = 1'b1
  } bl_state_e;

  typedef struct packed {
    alu_op_e     alu_op;
    shift_op_e   shifter_op;
    logic        shift_en;
    logic [3:0]  r_addr1;
    logic [3:0]  r_addr2;
    logic [3:0]  w_addr;
    logic        we;
    logic [31:0] imm;
    logic        imm_sel;
    logic        move;
    logic        l_s;
    logic        mem_en;
    logic        branch;
    logic        branch_reg;
    logic        link;
    logic [3:0]  cond;
    logic        illegal;
  } bundle_t;

  function automatic bundle_t default_bundle();
    bundle_t b;
    b            = '0;
    b.alu_op     = ALU_NONE;
    b.shifter_op = SH_LSL;
    b.cond       = COND_AL;
    return b;
  endfunction

  function automatic bundle_t illegal_bundle();
    bundle_t b;
    b         = default_bundle();
    b.illegal = 1'b1;
    return b;
  endfunction

  // Second half of BL: offset is {hi11, lo11, 0}, sign-extended from bit 22.
  function automatic bundle_t bl_bundle(input logic [10:0] hi, input logic [10:0] lo);
    bundle_t b;
    b        = default_bundle();
    b.branch = 1'b1;
    b.link   = 1'b1;
    b.we     = 1'b1;
    b.w_addr = LR_IDX;
    b.imm    = {{9{hi[10]}}, hi, lo, 1'b0};
    return b;
  endfunction

endpackage

// File: rtl/decode_comb.sv
// rtl/decode_comb.sv - combinational halfword-to-bundle decode table
//
// Ports:
//   instr  in  16        instruction halfword
//   bundle out bundle_t  decoded fields; BL halfwords decode as illegal here,
//                        the BL pair is sequenced by decode_stage
module decode_comb
  import decode_pkg::*;
(
  input  logic [15:0] instr,
  output bundle_t     bundle
);

  always_comb begin
    bundle = default_bundle();
    casez (instr)
      16'b0001_10??_????_????: begin
        bundle.alu_op  = instr[9] ? ALU_SUB : ALU_ADD;
        bundle.r_addr1 = {1'b0, instr[5:3]};
        bundle.r_addr2 = {1'b0, instr[8:6]};
        bundle.w_addr  = {1'b0, instr[2:0]};
        bundle.we      = 1'b1;
      end
      16'b0001_11??_????_????: begin
        bundle.alu_op  = instr[9] ? ALU_SUB : ALU_ADD;
        bundle.r_addr1 = {1'b0, instr[5:3]};
        bundle.w_addr  = {1'b0, instr[2:0]};
        bundle.we      = 1'b1;
        bundle.imm     = {29'b0, instr[8:6]};
        bundle.imm_sel = 1'b1;
      end
      16'b0010_0???_????_????: begin
        bundle.w_addr  = {1'b0, instr[10:8]};
        bundle.we      = 1'b1;
        bundle.imm     = {24'b0, instr[7:0]};
        bundle.imm_sel = 1'b1;
      end
      16'b0100_00??_????_????: begin
        bundle.r_addr1 = {1'b0, instr[2:0]};
        bundle.r_addr2 = {1'b0, instr[5:3]};
        bundle.w_addr  = {1'b0, instr[2:0]};
        bundle.we      = 1'b1;
        case (instr[9:6])
          4'b0000: bundle.alu_op = ALU_AND;
          4'b0001: bundle.alu_op = ALU_EOR;
          4'b1100: bundle.alu_op = ALU_ORR;
          4'b1111: bundle.alu_op = ALU_MVN;
          4'b0010: begin bundle.shift_en = 1'b1; bundle.shifter_op = SH_LSL; end
          4'b0011: begin bundle.shift_en = 1'b1; bundle.shifter_op = SH_LSR; end
          4'b0100: begin bundle.shift_en = 1'b1; bundle.shifter_op = SH_ASR; end
          4'b0111: begin bundle.shift_en = 1'b1; bundle.shifter_op = SH_ROR; end
          4'b1010: begin bundle.alu_op = ALU_CMP; bundle.we = 1'b0; end
          default: bundle = illegal_bundle();
        endcase
      end
      16'b0100_0110_????_????: begin
        // Hi-register MOV: destination high bit comes from D (bit 7).
        bundle.w_addr  = {instr[7], instr[2:0]};
        bundle.r_addr1 = instr[6:3];
        bundle.move    = 1'b1;
        bundle.we      = 1'b1;
      end
      16'b0100_0111_0???_?000: begin
        bundle.branch_reg = 1'b1;
        bundle.r_addr1    = instr[6:3];
      end
      16'b0110_????_????_????: begin
        bundle.mem_en  = 1'b1;
        bundle.imm     = {25'b0, instr[10:6], 2'b00};
        bundle.imm_sel = 1'b1;
        bundle.r_addr1 = {1'b0, instr[5:3]};
        if (instr[11]) begin
          bundle.l_s    = 1'b0;
          bundle.w_addr = {1'b0, instr[2:0]};
          bundle.we     = 1'b1;
        end else begin
          bundle.l_s     = 1'b1;
          bundle.r_addr2 = {1'b0, instr[2:0]};
        end
      end
      16'b1011_0000_????_????: begin
        bundle.alu_op  = instr[7] ? ALU_SUB : ALU_ADD;
        bundle.r_addr1 = SP_IDX;
        bundle.w_addr  = SP_IDX;
        bundle.we      = 1'b1;
        bundle.imm     = {23'b0, instr[6:0], 2'b00};
        bundle.imm_sel = 1'b1;
      end
      16'b1011_1111_0000_0000: begin
        bundle = default_bundle();
      end
      16'b1101_????_????_????: begin
        // AL and NV are not valid conditional-branch conditions.
        if (instr[11:8] == COND_AL || instr[11:8] == COND_NV) begin
          bundle = illegal_bundle();
        end else begin
          bundle.branch = 1'b1;
          bundle.cond   = instr[11:8];
          bundle.imm    = {{23{instr[7]}}, instr[7:0], 1'b0};
        end
      end
      16'b1110_0???_????_????: begin
        bundle.branch = 1'b1;
        bundle.imm    = {{20{instr[10]}}, instr[10:0], 1'b0};
      end
      default: begin
        bundle = illegal_bundle();
      end
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered valid/ready decode stage with BL sequencer
//
// Optional: define DECODE_STATS_EN to add stat_decoded / stat_illegal counters.
// Ports:
//   clk, reset (async active-low), flush
//   in_valid/in_ready/instruction   upstream halfword handshake
//   out_valid/out_ready             downstream bundle handshake
//   alu_op, shifter_op, shift_en, r_addr1, r_addr2, w_addr, we, imm, imm_sel,
//   move, l_s, mem_en, branch, branch_reg, link, cond, illegal  decoded bundle
//   stat_decoded, stat_illegal      emitted / illegal bundle counts (optional)
module decode_stage
  import decode_pkg::*;
#(
  parameter int REG_AW = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       instruction,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        alu_op,
  output logic [1:0]        shifter_op,
  output logic              shift_en,
  output logic [REG_AW-1:0] r_addr1,
  output logic [REG_AW-1:0] r_addr2,
  output logic [REG_AW-1:0] w_addr,
  output logic              we,
  output logic [DATA_W-1:0] imm,
  output logic              imm_sel,
  output logic              move,
  output logic              l_s,
  output logic              mem_en,
  output logic              branch,
  output logic              branch_reg,
  output logic              link,
  output logic [3:0]        cond,
  output logic              illegal
`ifdef DECODE_STATS_EN
  ,
  output logic [31:0]       stat_decoded,
  output logic [31:0]       stat_illegal
`endif
);

  bl_state_e   state_q, state_d;
  logic [10:0] hi_q, hi_d;
  logic        out_valid_q, out_valid_d;
  bundle_t     bundle_q, bundle_d;
  bundle_t     comb_bundle;
  logic        accept;
  logic        emit;

  decode_comb u_decode_comb (
    .instr  (instruction),
    .bundle (comb_bundle)
  );

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    out_valid_d = out_valid_q;
    bundle_d    = bundle_q;
    emit        = 1'b0;

    if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (flush) begin
      out_valid_d = 1'b0;
      state_d     = ST_IDLE;
    end else if (accept) begin
      if (state_q == ST_IDLE) begin
        if (instruction[15:11] == BL_HI_PFX) begin
          // BL prefix only latches the high offset; nothing is emitted.
          hi_d    = instruction[10:0];
          state_d = ST_BL_WAIT;
        end else begin
          bundle_d = comb_bundle;
          emit     = 1'b1;
        end
      end else begin
        state_d = ST_IDLE;
        emit    = 1'b1;
        if (instruction[15:11] == BL_LO_PFX) begin
          bundle_d = bl_bundle(hi_q, instruction[10:0]);
        end else begin
          bundle_d = illegal_bundle();
        end
      end
      // An accept implies any previous bundle has been taken this cycle.
      out_valid_d = emit;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      hi_q        <= '0;
      out_valid_q <= 1'b0;
      bundle_q    <= default_bundle();
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      out_valid_q <= out_valid_d;
      bundle_q    <= bundle_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign alu_op     = bundle_q.alu_op;
  assign shifter_op = bundle_q.shifter_op;
  assign shift_en   = bundle_q.shift_en;
  assign r_addr1    = REG_AW'(bundle_q.r_addr1);
  assign r_addr2    = REG_AW'(bundle_q.r_addr2);
  assign w_addr     = REG_AW'(bundle_q.w_addr);
  assign we         = bundle_q.we;
  // Zero-extended immediates have bit 31 clear, so sign-resizing is correct for all.
  assign imm        = DATA_W'($signed(bundle_q.imm));
  assign imm_sel    = bundle_q.imm_sel;
  assign move       = bundle_q.move;
  assign l_s        = bundle_q.l_s;
  assign mem_en     = bundle_q.mem_en;
  assign branch     = bundle_q.branch;
  assign branch_reg = bundle_q.branch_reg;
  assign link       = bundle_q.link;
  assign cond       = bundle_q.cond;
  assign illegal    = bundle_q.illegal;

`ifdef DECODE_STATS_EN
  logic [31:0] stat_decoded_q, stat_decoded_d;
  logic [31:0] stat_illegal_q, stat_illegal_d;

  always_comb begin
    stat_decoded_d = stat_decoded_q;
    stat_illegal_d = stat_illegal_q;
    if (emit) begin
      stat_decoded_d = stat_decoded_q + 32'd1;
      if (bundle_d.illegal) begin
        stat_illegal_d = stat_illegal_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_decoded_q <= '0;
      stat_illegal_q <= '0;
    end else begin
      stat_decoded_q <= stat_decoded_d;
      stat_illegal_q <= stat_illegal_d;
    end
  end

  assign stat_decoded = stat_decoded_q;
  assign stat_illegal = stat_illegal_q;
`endif

endmodule
